// File: rtl/ram_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_responder_if
// Purpose  : Cache-controller <-> main-memory request/response bundle.
// Revision : 1.0
// ============================================================================
interface ram_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  RAMreadEnable;
  logic                  RAMwriteEnable;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] writeData;
  logic [DATA_WIDTH-1:0] readData;
  logic                  dataReady;
  logic                  busy;
  logic                  protocolError;

  modport master (
    output RAMreadEnable, RAMwriteEnable, addr, writeData,
    input  readData, dataReady, busy, protocolError
  );

  modport slave (
    input  RAMreadEnable, RAMwriteEnable, addr, writeData,
    output readData, dataReady, busy, protocolError
  );
endinterface
`default_nettype wire

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : ram_responder
// Purpose  : Fixed-latency main-memory responder with write-back-then-fetch.
// Revision : 1.0
// ============================================================================
module ram_responder #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_responder_if.slave bus
);

  localparam int        DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
  localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_WAIT = 2'd1,
    READ_WAIT  = 2'd2,
    READ_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic                  data_ready_q;
  logic                  busy_q;
  logic                  perr_q, perr_d;
  logic                  mem_we;
  logic                  load_rd;

  // Backing array deliberately has no reset so its contents survive rst_n.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_addr_d    = rd_addr_q;
    rd_pending_d = rd_pending_q;
    mem_we       = 1'b0;
    load_rd      = 1'b0;
    perr_d       = perr_q | (bus.RAMwriteEnable && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (bus.RAMwriteEnable) begin
          wr_addr_d = bus.addr;
          wr_data_d = bus.writeData;
          lat_d     = WR_LAT;
          state_d   = WRITE_WAIT;
          if (bus.RAMreadEnable) begin
            rd_addr_d    = bus.addr;
            rd_pending_d = 1'b1;
          end
        end else if (bus.RAMreadEnable) begin
          rd_addr_d = bus.addr;
          lat_d     = RD_LAT;
          state_d   = READ_WAIT;
        end
      end

      WRITE_WAIT: begin
        lat_d = lat_q - 4'd1;
        if (bus.RAMreadEnable && !rd_pending_q) begin
          rd_addr_d    = bus.addr;
          rd_pending_d = 1'b1;
        end
        // A fetch arriving on the commit cycle itself is chained, not dropped.
        if (lat_q == 4'd1) begin
          mem_we       = 1'b1;
          rd_pending_d = 1'b0;
          if (rd_pending_q || bus.RAMreadEnable) begin
            lat_d   = RD_LAT;
            state_d = READ_WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end

      READ_WAIT: begin
        lat_d = lat_q - 4'd1;
        if (!bus.RAMreadEnable) begin
          state_d = IDLE;
        end else if (lat_q == 4'd1) begin
          load_rd = 1'b1;
          state_d = READ_DONE;
        end
      end

      READ_DONE: begin
        if (!bus.RAMreadEnable) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lat_q        <= 4'd0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_addr_q    <= '0;
      rd_pending_q <= 1'b0;
      read_data_q  <= '0;
      data_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_addr_q    <= rd_addr_d;
      rd_pending_q <= rd_pending_d;
      if (load_rd) begin
        read_data_q <= mem_q[rd_addr_q];
      end
      data_ready_q <= (state_d == READ_DONE);
      busy_q       <= (state_d == WRITE_WAIT);
      perr_q       <= perr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_addr_q] <= wr_data_q;
    end
  end

  assign bus.readData      = read_data_q;
  assign bus.dataReady     = data_ready_q;
  assign bus.busy          = busy_q;
  assign bus.protocolError = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_responder
// Purpose  : Scoreboard bench for ram_responder.
// Revision : 1.0
// ============================================================================
module tb_ram_responder;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int RL = 4;
  localparam int WL = 2;

  logic clk = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] model [256];
  logic [DW-1:0] sb_q [$];

  ram_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_responder #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.dataReady && n < 64) begin
      cycle();
      n++;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.RAMwriteEnable = 1'b1;
    bus.addr           = a;
    bus.writeData      = d;
    model[a]           = d;
    cycle();
    bus.RAMwriteEnable = 1'b0;
    for (int i = 0; i < WL; i++) begin
      chk("wr_busy_hi", 32'(bus.busy), 32'd1);
      cycle();
    end
    chk("wr_busy_lo", 32'(bus.busy), 32'd0);
  endtask

  task automatic end_read();
    bus.RAMreadEnable = 1'b0;
    cycle();
    chk("rd_drop", 32'(bus.dataReady), 32'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold);
    int n;
    logic [DW-1:0] exp;
    bus.RAMreadEnable = 1'b1;
    bus.addr          = a;
    sb_q.push_back(model[a]);
    cycle();
    wait_ready(n);
    chk("rd_latency", n, 32'(RL));
    exp = sb_q.pop_front();
    chk("rd_data", 32'(bus.readData), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      cycle();
      chk("rd_hold_rdy", 32'(bus.dataReady), 32'd1);
      chk("rd_hold_data", 32'(bus.readData), 32'(exp));
    end
    end_read();
  endtask

  initial begin
    int n;
    logic seen;
    logic [DW-1:0] exp;

    rst_n              = 1'b0;
    bus.RAMreadEnable  = 1'b0;
    bus.RAMwriteEnable = 1'b0;
    bus.addr           = '0;
    bus.writeData      = '0;
    repeat (3) @(negedge clk);
    chk("rst_readData", 32'(bus.readData), 32'd0);
    chk("rst_dataReady", 32'(bus.dataReady), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_perr", 32'(bus.protocolError), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_write(8'h10, 16'hBEEF);
    do_write(8'h30, 16'h5555);
    do_write(8'h50, 16'h1111);
    do_write(8'h60, 16'h2222);
    do_write(8'h61, 16'h3333);

    // Plain read, held three extra cycles.
    do_read(8'h10, 3);

    // Write-back of 0x20 followed by a held fetch of 0x30.
    bus.RAMwriteEnable = 1'b1;
    bus.addr           = 8'h20;
    bus.writeData      = 16'h1234;
    model[8'h20]       = 16'h1234;
    cycle();
    bus.RAMwriteEnable = 1'b0;
    bus.RAMreadEnable  = 1'b1;
    bus.addr           = 8'h30;
    sb_q.push_back(model[8'h30]);
    chk("wf_busy_e0", 32'(bus.busy), 32'd1);
    cycle();
    chk("wf_busy_e1", 32'(bus.busy), 32'd1);
    cycle();
    chk("wf_busy_e2", 32'(bus.busy), 32'd0);
    wait_ready(n);
    chk("wf_latency", n + WL, 32'(WL + RL));
    exp = sb_q.pop_front();
    chk("wf_data", 32'(bus.readData), 32'(exp));
    end_read();
    do_read(8'h20, 0);

    // Simultaneous write and read of the same word.
    bus.RAMwriteEnable = 1'b1;
    bus.RAMreadEnable  = 1'b1;
    bus.addr           = 8'h40;
    bus.writeData      = 16'hA5A5;
    model[8'h40]       = 16'hA5A5;
    sb_q.push_back(model[8'h40]);
    cycle();
    bus.RAMwriteEnable = 1'b0;
    wait_ready(n);
    chk("raw_latency", n, 32'(WL + RL));
    exp = sb_q.pop_front();
    chk("raw_data", 32'(bus.readData), 32'(exp));
    chk("raw_perr", 32'(bus.protocolError), 32'd0);
    end_read();

    // Second write strobe while the first is still committing.
    bus.RAMwriteEnable = 1'b1;
    bus.addr           = 8'h48;
    bus.writeData      = 16'h7777;
    model[8'h48]       = 16'h7777;
    cycle();
    bus.addr      = 8'h50;
    bus.writeData = 16'hDEAD;
    chk("ill_perr_pre", 32'(bus.protocolError), 32'd0);
    cycle();
    bus.RAMwriteEnable = 1'b0;
    chk("ill_perr_set", 32'(bus.protocolError), 32'd1);
    repeat (4) cycle();
    chk("ill_perr_sticky", 32'(bus.protocolError), 32'd1);
    do_read(8'h50, 0);
    do_read(8'h48, 0);

    // Abort a read two cycles into its latency.
    bus.RAMreadEnable = 1'b1;
    bus.addr          = 8'h30;
    cycle();
    cycle();
    cycle();
    bus.RAMreadEnable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      seen = seen | bus.dataReady;
    end
    chk("abort_no_ready", 32'(seen), 32'd0);
    do_read(8'h10, 0);

    // Reset between acceptance and commit of a write.
    bus.RAMwriteEnable = 1'b1;
    bus.addr           = 8'h60;
    bus.writeData      = 16'hFFFF;
    cycle();
    bus.RAMwriteEnable = 1'b0;
    chk("mrst_busy_pre", 32'(bus.busy), 32'd1);
    chk("mrst_perr_pre", 32'(bus.protocolError), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_perr", 32'(bus.protocolError), 32'd0);
    chk("mrst_ready", 32'(bus.dataReady), 32'd0);
    chk("mrst_rdata", 32'(bus.readData), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(8'h60, 0);
    do_read(8'h61, 0);
    do_read(8'h30, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
